vc_lfdb_mc: RTL and testbench

- Parametrised multi-entry linefill data buffer for the vector cache. Successor to the fixed 32-entry LFDB: entry count, bus width and line width are parameters, and it adds interleaved multi-entry fill, a per-entry sideband command store and round-robin drain.
- MSHR allocates an entry before issuing a linefill. Downstream returns BUS_WIDTH beats tagged with the entry id.
- A completed line is presented as one LINE_WIDTH word to the RAM write path, then the entry is freed.

---
 rtl/vc_lfdb_mc.sv | 226 ++++++++++++++++++++++
 tb/tb_vc_lfdb_mc.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_lfdb_mc.sv
// Purpose: parametrised linefill data buffer; MSHR allocates entries, tagged downstream
//          beats assemble lines, completed lines drain round-robin through one output register.
// Latency: last beat accepted in cycle N -> entry FULL in N+1 -> done_vld in N+2 (output idle).
// Backpressure: ds_rdy is always high outside reset; done_* hold until done_vld & done_rdy.
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   alloc_req/alloc_cmd              allocation request and sideband captured on grant
//   alloc_gnt/alloc_id               combinational grant and lowest-index free entry
//   free_cnt                         registered count of FREE entries
//   ds_vld/ds_rdy/ds_entry_id/ds_data/ds_last   downstream beat channel
//   done_vld/done_rdy/done_entry_id/done_data/done_cmd   completed line channel
//   err                              sticky protocol error
module vc_lfdb_mc #(
  parameter int ENTRY_NUM  = 32,
  parameter int BUS_WIDTH  = 128,
  parameter int LINE_WIDTH = 1024,
  parameter int CMD_WIDTH  = 64,
  parameter int ID_W       = $clog2(ENTRY_NUM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_req,
  input  logic [CMD_WIDTH-1:0]  alloc_cmd,
  output logic                  alloc_gnt,
  output logic [ID_W-1:0]       alloc_id,
  output logic [ID_W:0]         free_cnt,
  input  logic                  ds_vld,
  output logic                  ds_rdy,
  input  logic [ID_W-1:0]       ds_entry_id,
  input  logic [BUS_WIDTH-1:0]  ds_data,
  input  logic                  ds_last,
  output logic                  done_vld,
  input  logic                  done_rdy,
  output logic [ID_W-1:0]       done_entry_id,
  output logic [LINE_WIDTH-1:0] done_data,
  output logic [CMD_WIDTH-1:0]  done_cmd,
  output logic                  err
);

  localparam int BEATS = LINE_WIDTH / BUS_WIDTH;
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(BEATS - 1);
  localparam logic [ID_W:0]    FREE_ALL  = (ID_W+1)'(ENTRY_NUM);

  typedef enum logic [1:0] {
    ST_FREE = 2'd0,
    ST_FILL = 2'd1,
    ST_FULL = 2'd2
  } ent_st_e;

  // Per-entry control state (reset) and line/sideband storage (not reset).
  ent_st_e                         st_q [ENTRY_NUM];
  ent_st_e                         st_d [ENTRY_NUM];
  logic [ENTRY_NUM-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [LINE_WIDTH-1:0]           line_q [ENTRY_NUM];
  logic [CMD_WIDTH-1:0]            cmd_q  [ENTRY_NUM];

  logic [ID_W:0]         free_cnt_q, free_cnt_d;
  logic                  err_q, err_d;
  logic [ID_W-1:0]       rr_q, rr_d;
  logic                  out_vld_q, out_vld_d;
  logic [ID_W-1:0]       out_id_q, out_id_d;
  logic [LINE_WIDTH-1:0] out_data_q;
  logic [CMD_WIDTH-1:0]  out_cmd_q;

  logic            alloc_found;
  logic [ID_W-1:0] alloc_idx;
  logic            grant;
  logic            beat_acc;
  logic            beat_wr;
  logic [CNT_W-1:0] wr_slot;
  logic            drain_hs;
  logic            load_en;
  logic            load_fire;
  logic            sel_found;
  logic [ID_W-1:0] sel_idx;
  logic [ID_W-1:0] scan_idx;

  // Lowest-index FREE entry: scan downwards so the last hit is the lowest.
  always_comb begin
    alloc_found = 1'b0;
    alloc_idx   = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (st_q[i] == ST_FREE) begin
        alloc_found = 1'b1;
        alloc_idx   = ID_W'(i);
      end
    end
  end

  assign grant    = alloc_req & alloc_found;
  assign beat_acc = ds_vld & ~rst;
  assign drain_hs = out_vld_q & done_rdy;
  assign load_en  = ~out_vld_q | drain_hs;

  // Round-robin pick of a FULL entry starting at rr_q. The entry already sitting
  // in the output register is still FULL until its handshake retires it, so it
  // is masked out to avoid presenting it twice.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    scan_idx  = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      scan_idx = rr_q + ID_W'(i);
      if (!sel_found && (st_q[scan_idx] == ST_FULL) &&
          !(out_vld_q && (scan_idx == out_id_q))) begin
        sel_found = 1'b1;
        sel_idx   = scan_idx;
      end
    end
  end

  assign load_fire = load_en & sel_found;

  // Next-state for entry FSMs, beat counters, error flag, free count and output register.
  // Grant targets a FREE entry, beats only act on FILL entries and the drain retires a
  // FULL entry, so the three never collide on one entry in the same cycle.
  always_comb begin
    st_d       = st_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    free_cnt_d = free_cnt_q;
    rr_d       = rr_q;
    out_vld_d  = out_vld_q;
    out_id_d   = out_id_q;
    beat_wr    = 1'b0;
    wr_slot    = cnt_q[ds_entry_id];

    if (grant) begin
      st_d[alloc_idx]  = ST_FILL;
      cnt_d[alloc_idx] = '0;
    end

    if (beat_acc) begin
      if (st_q[ds_entry_id] == ST_FILL) begin
        beat_wr = 1'b1;
        if (ds_last) begin
          // An early last still closes the line so the entry can drain.
          st_d[ds_entry_id]  = ST_FULL;
          cnt_d[ds_entry_id] = '0;
          if (wr_slot != LAST_SLOT) begin
            err_d = 1'b1;
          end
        end else if (wr_slot == LAST_SLOT) begin
          // Missing last: wrap and keep filling, flag the violation.
          cnt_d[ds_entry_id] = '0;
          err_d              = 1'b1;
        end else begin
          cnt_d[ds_entry_id] = wr_slot + 1'b1;
        end
      end else begin
        err_d = 1'b1;
      end
    end

    if (drain_hs) begin
      st_d[out_id_q] = ST_FREE;
    end

    if (grant && !drain_hs) begin
      free_cnt_d = free_cnt_q - 1'b1;
    end else if (!grant && drain_hs) begin
      free_cnt_d = free_cnt_q + 1'b1;
    end

    if (load_fire) begin
      out_vld_d = 1'b1;
      out_id_d  = sel_idx;
      rr_d      = sel_idx + 1'b1;
    end else if (drain_hs) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        st_q[i] <= ST_FREE;
      end
      cnt_q      <= '0;
      err_q      <= 1'b0;
      free_cnt_q <= FREE_ALL;
      rr_q       <= '0;
      out_vld_q  <= 1'b0;
      out_id_q   <= '0;
    end else begin
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      free_cnt_q <= free_cnt_d;
      rr_q       <= rr_d;
      out_vld_q  <= out_vld_d;
      out_id_q   <= out_id_d;
    end
  end

  // Datapath storage: contents are only meaningful while the owning entry is live.
  always_ff @(posedge clk) begin
    if (grant) begin
      cmd_q[alloc_idx] <= alloc_cmd;
    end
    if (beat_wr) begin
      for (int k = 0; k < BEATS; k++) begin
        if (wr_slot == CNT_W'(k)) begin
          line_q[ds_entry_id][k*BUS_WIDTH +: BUS_WIDTH] <= ds_data;
        end
      end
    end
    if (load_fire) begin
      out_data_q <= line_q[sel_idx];
      out_cmd_q  <= cmd_q[sel_idx];
    end
  end

  assign alloc_gnt     = grant;
  assign alloc_id      = alloc_idx;
  assign free_cnt      = free_cnt_q;
  assign ds_rdy        = ~rst;
  assign done_vld      = out_vld_q;
  assign done_entry_id = out_id_q;
  assign done_data     = out_data_q;
  assign done_cmd      = out_cmd_q;
  assign err           = err_q;

endmodule

// File: tb/tb_vc_lfdb_mc.sv
// Purpose: self-checking bench for vc_lfdb_mc: directed scenarios plus a randomized phase
//          checked against a line-level model of entry lifetimes.
// Timing: inputs driven and outputs sampled 1 time unit after the rising edge.
module tb_vc_lfdb_mc;
  localparam int N     = 32;
  localparam int BW    = 128;
  localparam int LW    = 1024;
  localparam int CW    = 64;
  localparam int IW    = 5;
  localparam int BEATS = LW / BW;

  logic          clk;
  logic          rst;
  logic          alloc_req;
  logic [CW-1:0] alloc_cmd;
  logic          alloc_gnt;
  logic [IW-1:0] alloc_id;
  logic [IW:0]   free_cnt;
  logic          ds_vld;
  logic          ds_rdy;
  logic [IW-1:0] ds_entry_id;
  logic [BW-1:0] ds_data;
  logic          ds_last;
  logic          done_vld;
  logic          done_rdy;
  logic [IW-1:0] done_entry_id;
  logic [LW-1:0] done_data;
  logic [CW-1:0] done_cmd;
  logic          err;

  vc_lfdb_mc #(
    .ENTRY_NUM(N), .BUS_WIDTH(BW), .LINE_WIDTH(LW), .CMD_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_cmd(alloc_cmd), .alloc_gnt(alloc_gnt), .alloc_id(alloc_id),
    .free_cnt(free_cnt),
    .ds_vld(ds_vld), .ds_rdy(ds_rdy), .ds_entry_id(ds_entry_id), .ds_data(ds_data),
    .ds_last(ds_last),
    .done_vld(done_vld), .done_rdy(done_rdy), .done_entry_id(done_entry_id),
    .done_data(done_data), .done_cmd(done_cmd), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Line-level model: 0 = free, 1 = filling, 2 = complete.
  int            m_st   [N];
  int            m_cnt  [N];
  logic [LW-1:0] m_line [N];
  logic [CW-1:0] m_cmd  [N];

  logic [LW-1:0] ones;
  logic [LW-1:0] la, lb, lc, mask;
  logic [LW-1:0] il [3];
  int            ord [3];
  int            n;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    int k;
    k = 0;
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      for (int i = BEATS - 1; i >= 0; i--) if (obs[i*BW +: BW] !== exp[i*BW +: BW]) k = i;
      $error("FAIL %s: observed %0h expected %0h (128-bit word %0d)",
             tag, obs[k*BW +: BW], exp[k*BW +: BW], k);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    alloc_req = 1'b0; ds_vld = 1'b0; ds_last = 1'b0; done_rdy = 1'b0;
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic do_alloc(input logic [CW-1:0] cmd, input int exp_id);
    alloc_req = 1'b1;
    alloc_cmd = cmd;
    #1;
    chk("alloc_gnt", alloc_gnt, 1'b1);
    chk("alloc_id", alloc_id, exp_id);
    cyc();
    alloc_req = 1'b0;
  endtask

  task automatic do_beat(input int id, input logic [BW-1:0] d, input logic last);
    ds_vld = 1'b1; ds_entry_id = IW'(id); ds_data = d; ds_last = last;
    cyc();
    ds_vld = 1'b0; ds_last = 1'b0;
  endtask

  task automatic fill_line(input int id, input logic [LW-1:0] line);
    for (int k = 0; k < BEATS; k++) do_beat(id, line[k*BW +: BW], k == BEATS - 1);
  endtask

  task automatic wait_vld();
    int w;
    w = 0;
    while (done_vld !== 1'b1 && w < 40) begin
      cyc();
      w++;
    end
  endtask

  task automatic expect_drain(input string tag, input int id, input logic [LW-1:0] line,
                              input logic [CW-1:0] cmd, input logic [LW-1:0] msk);
    wait_vld();
    chk({tag, "_vld"}, done_vld, 1'b1);
    chk({tag, "_id"}, done_entry_id, id);
    chk({tag, "_data"}, done_data & msk, line & msk);
    chk({tag, "_cmd"}, done_cmd, cmd);
    done_rdy = 1'b1;
    cyc();
    done_rdy = 1'b0;
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // One random cycle. en=0 stops allocating and keeps the consumer ready so the
  // buffer empties; open fills are still completed.
  task automatic rnd_cycle(input bit en);
    int fq[$];
    int be, exp_id, hs_id, nfree;
    logic [BW-1:0] bd;
    be = -1; exp_id = -1; hs_id = -1; nfree = 0; bd = '0;
    ds_vld = 1'b0; ds_last = 1'b0;
    alloc_req = en && ($urandom_range(0, 9) < 3);
    alloc_cmd = {$urandom, $urandom};
    for (int e = 0; e < N; e++) if (m_st[e] == 1) fq.push_back(e);
    if (fq.size() > 0 && (!en || $urandom_range(0, 9) < 7)) begin
      be = fq[$urandom_range(0, fq.size() - 1)];
      bd = {$urandom, $urandom, $urandom, $urandom};
      ds_vld = 1'b1; ds_entry_id = IW'(be); ds_data = bd; ds_last = (m_cnt[be] == BEATS - 1);
    end
    done_rdy = en ? ($urandom_range(0, 1) == 1) : 1'b1;
    #1;
    for (int e = N - 1; e >= 0; e--) if (m_st[e] == 0) exp_id = e;
    chk("rnd_gnt", alloc_gnt, alloc_req && exp_id >= 0);
    if (alloc_req && exp_id >= 0) chk("rnd_alloc_id", alloc_id, exp_id);
    if (done_vld === 1'b1) begin
      hs_id = int'(done_entry_id);
      chk("rnd_drain_complete", m_st[hs_id], 2);
      chk("rnd_drain_data", done_data, m_line[hs_id]);
      chk("rnd_drain_cmd", done_cmd, m_cmd[hs_id]);
      if (!done_rdy) hs_id = -1;
    end
    cyc();
    ds_vld = 1'b0; ds_last = 1'b0;
    if (alloc_req && exp_id >= 0) begin
      m_st[exp_id] = 1; m_cnt[exp_id] = 0; m_cmd[exp_id] = alloc_cmd;
    end
    if (be >= 0) begin
      m_line[be][m_cnt[be]*BW +: BW] = bd;
      m_cnt[be]++;
      if (m_cnt[be] == BEATS) begin
        m_st[be] = 2; m_cnt[be] = 0;
      end
    end
    if (hs_id >= 0) m_st[hs_id] = 0;
    for (int e = 0; e < N; e++) if (m_st[e] == 0) nfree++;
    chk("rnd_free_cnt", free_cnt, nfree);
    alloc_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    ones = '1;
    rst = 1'b0; alloc_req = 1'b0; alloc_cmd = '0; ds_vld = 1'b0; ds_entry_id = '0;
    ds_data = '0; ds_last = 1'b0; done_rdy = 1'b0;
    #3 rst = 1'b1;
    #2;
    chk("rst_done_vld", done_vld, 1'b0);
    chk("rst_free_cnt", free_cnt, N);
    chk("rst_err", err, 1'b0);
    chk("rst_ds_rdy", ds_rdy, 1'b0);
    cyc(); cyc();
    rst = 1'b0;
    #1;
    chk("ds_rdy_run", ds_rdy, 1'b1);

    // Single fill, beat k carries k.
    do_alloc(64'hA5, 0);
    chk("single_free_cnt", free_cnt, N - 1);
    for (int k = 0; k < BEATS; k++) la[k*BW +: BW] = BW'(k);
    fill_line(0, la);
    chk("single_vld_n1", done_vld, 1'b0);
    cyc();
    chk("single_vld_n2", done_vld, 1'b1);
    expect_drain("single", 0, la, 64'hA5, ones);
    chk("single_free_after", free_cnt, N);

    // Interleaved fills of 0,1,2; entry 2 completes first, rr then wraps to 0.
    ord[0] = 2; ord[1] = 0; ord[2] = 1;
    for (int e = 0; e < 3; e++) do_alloc(CW'(16 + e), e);
    for (int k = 0; k < BEATS; k++) begin
      for (int j = 0; j < 3; j++) begin
        il[ord[j]][k*BW +: BW] = BW'(ord[j] * 256 + k);
        do_beat(ord[j], BW'(ord[j] * 256 + k), k == BEATS - 1);
      end
    end
    expect_drain("il_e2", 2, il[2], CW'(18), ones);
    expect_drain("il_e0", 0, il[0], CW'(16), ones);
    expect_drain("il_e1", 1, il[1], CW'(17), ones);

    // Full buffer, then free entry 5 and see it re-granted.
    for (int i = 0; i < N; i++) do_alloc(CW'(i), i);
    chk("full_free_cnt", free_cnt, 0);
    alloc_req = 1'b1;
    #1;
    chk("full_gnt_low", alloc_gnt, 1'b0);
    alloc_req = 1'b0;
    lb = rand_line();
    fill_line(5, lb);
    wait_vld();
    chk("full_drain_id", done_entry_id, 5);
    chk("full_drain_data", done_data, lb);
    done_rdy = 1'b1; alloc_req = 1'b1;
    #1;
    chk("full_gnt_hs_cycle", alloc_gnt, 1'b0);
    cyc();
    done_rdy = 1'b0;
    chk("full_gnt_after", alloc_gnt, 1'b1);
    chk("full_id_after", alloc_id, 5);
    chk("full_free_one", free_cnt, 1);
    alloc_req = 1'b0;
    do_reset();

    // Backpressure: three complete lines, consumer stalled, then continuous ready.
    la = rand_line(); lb = rand_line(); lc = rand_line();
    do_alloc(CW'(32'h100), 0); do_alloc(CW'(32'h101), 1); do_alloc(CW'(32'h102), 2);
    fill_line(0, la); fill_line(1, lb); fill_line(2, lc);
    for (int i = 0; i < 10; i++) begin
      chk("bp_vld", done_vld, 1'b1);
      chk("bp_id", done_entry_id, 0);
      chk("bp_data", done_data, la);
      chk("bp_cmd", done_cmd, CW'(32'h100));
      cyc();
    end
    done_rdy = 1'b1;
    chk("bp_hs0_vld", done_vld, 1'b1);
    chk("bp_hs0_id", done_entry_id, 0);
    cyc();
    chk("bp_hs1_vld", done_vld, 1'b1);
    chk("bp_hs1_id", done_entry_id, 1);
    chk("bp_hs1_data", done_data, lb);
    cyc();
    chk("bp_hs2_vld", done_vld, 1'b1);
    chk("bp_hs2_id", done_entry_id, 2);
    chk("bp_hs2_data", done_data, lc);
    cyc();
    chk("bp_empty", done_vld, 1'b0);
    done_rdy = 1'b0;

    // Protocol errors: early last, then a beat to a FREE entry.
    chk("perr_clean", err, 1'b0);
    do_alloc(CW'(32'h77), 0);
    mask = '0;
    for (int k = 0; k < 4; k++) begin
      la[k*BW +: BW] = BW'(64 + k);
      mask[k*BW +: BW] = '1;
      do_beat(0, BW'(64 + k), k == 3);
    end
    chk("perr_early_last", err, 1'b1);
    expect_drain("perr_short", 0, la, CW'(32'h77), mask);
    do_beat(0, BW'(32'hDEAD), 1'b1);
    chk("perr_free_beat", err, 1'b1);
    chk("perr_free_cnt", free_cnt, N);
    do_alloc(CW'(32'h78), 0);
    lb = rand_line();
    fill_line(0, lb);
    expect_drain("perr_refill", 0, lb, CW'(32'h78), ones);
    chk("perr_sticky", err, 1'b1);

    // Reset mid-fill with an output pending.
    do_alloc(CW'(32'h90), 0);
    la = rand_line();
    fill_line(0, la);
    do_alloc(CW'(32'h91), 1);
    for (int k = 0; k < 4; k++) do_beat(1, BW'(k), 1'b0);
    chk("rmf_pending", done_vld, 1'b1);
    ds_vld = 1'b1; ds_entry_id = IW'(1); ds_data = BW'(4); rst = 1'b1;
    #1;
    chk("rmf_done_vld", done_vld, 1'b0);
    chk("rmf_free_cnt", free_cnt, N);
    chk("rmf_err", err, 1'b0);
    cyc();
    rst = 1'b0; ds_vld = 1'b0;
    do_alloc(CW'(32'h92), 0);
    lb = rand_line();
    fill_line(0, lb);
    expect_drain("rmf_after", 0, lb, CW'(32'h92), ones);
    chk("rmf_free_after", free_cnt, N);

    // Randomized traffic against the model, then drain everything.
    do_reset();
    for (int e = 0; e < N; e++) begin
      m_st[e] = 0; m_cnt[e] = 0; m_line[e] = '0; m_cmd[e] = '0;
    end
    for (int i = 0; i < 600; i++) rnd_cycle(1'b1);
    for (int i = 0; i < 400; i++) rnd_cycle(1'b0);
    chk("rnd_end_free_cnt", free_cnt, N);
    chk("rnd_end_vld", done_vld, 1'b0);
    chk("rnd_end_err", err, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
